// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the nibble-serial ALU sequencer.
// Select/mode codes follow the 74181 active-high function table.
`timescale 1ns/1ps
package alu_seq_pkg;
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] sel;
    logic       mode;
    logic       cin;
  } op_t;

  localparam logic MODE_ARITH = 1'b0;
  localparam logic MODE_LOGIC = 1'b1;

  localparam op_t OP_ADD = '{sel: 4'b1001, mode: MODE_ARITH, cin: 1'b0};
  localparam op_t OP_SUB = '{sel: 4'b0110, mode: MODE_ARITH, cin: 1'b1};
  localparam op_t OP_XOR = '{sel: 4'b0110, mode: MODE_LOGIC, cin: 1'b0};
  localparam op_t OP_AND = '{sel: 4'b1011, mode: MODE_LOGIC, cin: 1'b0};
endpackage

// File: rtl/alu_seq_collect.sv
// Result assembly: indexed nibble write, carry chain register,
// running AND of the per-slice equality flags.
`timescale 1ns/1ps
import alu_seq_pkg::*;

module alu_seq_collect #(
  parameter int NIBBLES = 4,
  parameter int IDX_W   = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        i_load,
  input  logic                        i_cin,
  input  logic                        i_cap,
  input  logic [IDX_W-1:0]            i_idx,
  input  logic [NIBBLE_W-1:0]         i_f,
  input  logic                        i_cout,
  input  logic                        i_eq,
  output logic [NIBBLES*NIBBLE_W-1:0] o_result,
  output logic                        o_carry,
  output logic                        o_equal
);
  logic [NIBBLES*NIBBLE_W-1:0] r_result;
  logic                        r_carry;
  logic                        r_equal;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_result <= '0;
      r_carry  <= 1'b0;
      r_equal  <= 1'b0;
    end else if (i_load) begin
      r_result <= '0;
      r_carry  <= i_cin;
      r_equal  <= 1'b1;
    end else if (i_cap) begin
      r_result[i_idx*NIBBLE_W +: NIBBLE_W] <= i_f;
      r_carry  <= i_cout;
      r_equal  <= r_equal & i_eq;
    end
  end

  assign o_result = r_result;
  assign o_carry  = r_carry;
  assign o_equal  = r_equal;
endmodule

// File: rtl/alu_nibble_sequencer.sv
// Drives an external 4-bit ALU slice once per nibble, LSB first,
// chaining carry through a register; valid/ready on both sides.
`timescale 1ns/1ps
import alu_seq_pkg::*;

module alu_nibble_sequencer #(
  parameter  int NIBBLES = 4,
  localparam int W       = NIBBLE_W * NIBBLES
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [W-1:0]        op_a_i,
  input  logic [W-1:0]        op_b_i,
  input  logic [3:0]          sel_i,
  input  logic                mode_i,
  input  logic                carry_in_i,
  output logic [3:0]          alu_s_o,
  output logic                alu_m_o,
  output logic                alu_cn_o,
  output logic [NIBBLE_W-1:0] alu_a_o,
  output logic [NIBBLE_W-1:0] alu_b_o,
  input  logic [NIBBLE_W-1:0] alu_f_i,
  input  logic                alu_cout_i,
  input  logic                alu_eq_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [W-1:0]        result_o,
  output logic                carry_out_o,
  output logic                equal_o,
  output logic                busy_o
);
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

  state_t           r_state;
  state_t           w_next;
  logic [IDX_W-1:0] r_idx;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [3:0]       r_sel;
  logic             r_mode;
  logic             w_accept;
  logic             w_cap;

  assign w_accept = req_valid_i & req_ready_o;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sel   <= '0;
      r_mode  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a    <= op_a_i;
        r_b    <= op_b_i;
        r_sel  <= sel_i;
        r_mode <= mode_i;
        r_idx  <= '0;
      end else if (w_cap && r_idx != LAST) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // ALU drive is gated to RUN so the slice sees zeros when idle.
  always_comb begin
    w_next      = r_state;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    busy_o      = 1'b1;
    w_cap       = 1'b0;
    alu_s_o     = '0;
    alu_m_o     = 1'b0;
    alu_cn_o    = 1'b0;
    alu_a_o     = '0;
    alu_b_o     = '0;
    unique case (1'b1)
      (r_state == ST_IDLE): begin
        req_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (req_valid_i) w_next = ST_RUN;
      end
      (r_state == ST_RUN): begin
        w_cap    = 1'b1;
        alu_s_o  = r_sel;
        alu_m_o  = r_mode;
        alu_cn_o = carry_out_o;
        alu_a_o  = r_a[r_idx*NIBBLE_W +: NIBBLE_W];
        alu_b_o  = r_b[r_idx*NIBBLE_W +: NIBBLE_W];
        if (r_idx == LAST) w_next = ST_DONE;
      end
      (r_state == ST_DONE): begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  alu_seq_collect #(
    .NIBBLES (NIBBLES),
    .IDX_W   (IDX_W)
  ) u_collect (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .i_load   (w_accept),
    .i_cin    (carry_in_i),
    .i_cap    (w_cap),
    .i_idx    (r_idx),
    .i_f      (alu_f_i),
    .i_cout   (alu_cout_i),
    .i_eq     (alu_eq_i),
    .o_result (result_o),
    .o_carry  (carry_out_o),
    .o_equal  (equal_o)
  );
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer with a behavioural 74181-style slice
// and a word-level scoreboard of expected responses.
`timescale 1ns/1ps
import alu_seq_pkg::*;

module tb_alu_nibble_sequencer;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk_i = 1'b0;
  logic         rst_n_i = 1'b0;
  logic         req_valid_i = 1'b0;
  logic         req_ready_o;
  logic [W-1:0] op_a_i = '0;
  logic [W-1:0] op_b_i = '0;
  logic [3:0]   sel_i = '0;
  logic         mode_i = 1'b0;
  logic         carry_in_i = 1'b0;
  logic [3:0]   alu_s_o;
  logic         alu_m_o;
  logic         alu_cn_o;
  logic [3:0]   alu_a_o;
  logic [3:0]   alu_b_o;
  logic [3:0]   alu_f_i;
  logic         alu_cout_i;
  logic         alu_eq_i;
  logic         rsp_valid_o;
  logic         rsp_ready_i = 1'b0;
  logic [W-1:0] result_o;
  logic         carry_out_o;
  logic         equal_o;
  logic         busy_o;

  typedef struct packed {
    logic [W-1:0] res;
    logic         co;
    logic         eq;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  logic [4:0] alu_w;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // {cout, F}; logic-mode cout is the A+B+Cn carry so chaining is visible
  function automatic logic [4:0] slice(input logic [3:0] s, input logic m,
                                       input logic cn, input logic [3:0] a,
                                       input logic [3:0] b);
    logic [4:0] t;
    logic [3:0] f;
    if (!m) begin
      if (s == 4'b0110) t = {1'b0, a} + {1'b0, ~b} + {4'b0, cn};
      else              t = {1'b0, a} + {1'b0, b} + {4'b0, cn};
      return t;
    end
    t = {1'b0, a} + {1'b0, b} + {4'b0, cn};
    case (s)
      4'b0000: f = ~a;
      4'b0001: f = ~(a | b);
      4'b0010: f = ~a & b;
      4'b0011: f = 4'h0;
      4'b0100: f = ~(a & b);
      4'b0101: f = ~b;
      4'b0110: f = a ^ b;
      4'b0111: f = a & ~b;
      4'b1000: f = ~a | b;
      4'b1001: f = ~(a ^ b);
      4'b1010: f = b;
      4'b1011: f = a & b;
      4'b1100: f = 4'hF;
      4'b1101: f = a | ~b;
      4'b1110: f = a | b;
      default: f = a;
    endcase
    return {t[4], f};
  endfunction

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [3:0] s, input logic m,
                                 input logic cn);
    exp_t r;
    logic [4:0] t;
    logic c;
    logic e;
    c = cn;
    e = 1'b1;
    r.res = '0;
    for (int i = 0; i < N; i++) begin
      t = slice(s, m, c, a[i*4 +: 4], b[i*4 +: 4]);
      r.res[i*4 +: 4] = t[3:0];
      c = t[4];
      e = e & (&t[3:0]);
    end
    r.co = c;
    r.eq = e;
    return r;
  endfunction

  always_comb begin
    alu_w      = slice(alu_s_o, alu_m_o, alu_cn_o, alu_a_o, alu_b_o);
    alu_f_i    = alu_w[3:0];
    alu_cout_i = alu_w[4];
    alu_eq_i   = &alu_w[3:0];
  end

  alu_nibble_sequencer #(.NIBBLES(N)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .op_a_i      (op_a_i),
    .op_b_i      (op_b_i),
    .sel_i       (sel_i),
    .mode_i      (mode_i),
    .carry_in_i  (carry_in_i),
    .alu_s_o     (alu_s_o),
    .alu_m_o     (alu_m_o),
    .alu_cn_o    (alu_cn_o),
    .alu_a_o     (alu_a_o),
    .alu_b_o     (alu_b_o),
    .alu_f_i     (alu_f_i),
    .alu_cout_i  (alu_cout_i),
    .alu_eq_i    (alu_eq_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .result_o    (result_o),
    .carry_out_o (carry_out_o),
    .equal_o     (equal_o),
    .busy_o      (busy_o)
  );

  function automatic logic [33:0] all_outs();
    return {rsp_valid_o, busy_o, result_o, carry_out_o, equal_o,
            alu_s_o, alu_m_o, alu_cn_o, alu_a_o, alu_b_o};
  endfunction

  task automatic scramble();
    op_a_i     = W'($urandom);
    op_b_i     = W'($urandom);
    sel_i      = 4'($urandom);
    mode_i     = 1'($urandom);
    carry_in_i = 1'($urandom);
  endtask

  task automatic do_req(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] s, input logic m, input logic cn,
                        output int acc, output bit to);
    to = 1'b1;
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (req_ready_o) begin
        op_a_i = a;
        op_b_i = b;
        sel_i = s;
        mode_i = m;
        carry_in_i = cn;
        req_valid_i = 1'b1;
        sb_q.push_back(model(a, b, s, m, cn));
        @(posedge clk_i);
        #1;
        acc = cyc;
        req_valid_i = 1'b0;
        scramble();
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic get_rsp(output exp_t obs, output int at, output bit to);
    to = 1'b1;
    at = 0;
    obs = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (rsp_valid_o) begin
        obs = {result_o, carry_out_o, equal_o};
        at = cyc;
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic pop_exp(output exp_t e);
    if (sb_q.size() > 0) e = sb_q.pop_front();
    else e = 'x;
  endtask

  task automatic ack();
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    repeat (2) @(negedge clk_i);
    n_cmp++;
    if (all_outs() !== 34'd0) begin
      n_bad++;
      $display("FAIL reset_outs got %h want 0", all_outs());
    end
    rst_n_i = 1'b1;
    @(negedge clk_i);
    n_cmp++;
    if (req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ready got rdy=%b busy=%b want 1/0", req_ready_o, busy_o);
    end
  endtask

  task automatic test_vec(input string nm, input logic [W-1:0] a,
                          input logic [W-1:0] b, input op_t op, input logic cn,
                          input exp_t want);
    int acc, at;
    bit to;
    exp_t obs, e;
    do_req(a, b, op.sel, op.mode, cn, acc, to);
    get_rsp(obs, at, to);
    n_cmp++;
    if (to) begin
      n_bad++;
      $display("FAIL %s_timeout got no rsp_valid want rsp", nm);
    end
    n_cmp++;
    if (at - acc != N) begin
      n_bad++;
      $display("FAIL %s_latency got %0d want %0d", nm, at - acc, N);
    end
    pop_exp(e);
    n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL %s_sb got %h/%b/%b want %h/%b/%b", nm, obs.res, obs.co, obs.eq, e.res, e.co, e.eq);
    end
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s_fixed got %h/%b/%b want %h/%b/%b", nm, obs.res, obs.co, obs.eq, want.res, want.co, want.eq);
    end
    ack();
  endtask

  task automatic test_add();
    test_vec("add", 16'hFFFF, 16'h0001, OP_ADD, 1'b0, '{res: 16'h0000, co: 1'b1, eq: 1'b0});
  endtask

  task automatic test_xor();
    test_vec("xor", 16'hA5A5, 16'hFFFF, OP_XOR, 1'b0, '{res: 16'h5A5A, co: 1'b1, eq: 1'b0});
  endtask

  task automatic test_sub();
    test_vec("sub", 16'h3C3C, 16'h3C3C, OP_SUB, 1'b0, '{res: 16'hFFFF, co: 1'b0, eq: 1'b1});
  endtask

  task automatic test_backpressure();
    int acc, at;
    bit to;
    exp_t obs, e;
    logic [W-1:0] a2, b2;
    a2 = 16'h8421;
    b2 = 16'h1248;
    do_req(16'h1234, 16'h0FF1, OP_ADD.sel, OP_ADD.mode, 1'b1, acc, to);
    get_rsp(obs, at, to);
    pop_exp(e);
    n_cmp++;
    if (to || obs !== e) begin
      n_bad++;
      $display("FAIL bp_first got %h/%b/%b to=%b want %h/%b/%b", obs.res, obs.co, obs.eq, to, e.res, e.co, e.eq);
    end
    op_a_i = a2;
    op_b_i = b2;
    sel_i = OP_SUB.sel;
    mode_i = OP_SUB.mode;
    carry_in_i = OP_SUB.cin;
    req_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      n_cmp++;
      if (rsp_valid_o !== 1'b1 || req_ready_o !== 1'b0 ||
          {result_o, carry_out_o, equal_o} !== obs) begin
        n_bad++;
        $display("FAIL bp_hold%0d got v=%b r=%b %h want v=1 r=0 %h", k, rsp_valid_o, req_ready_o, result_o, obs.res);
      end
    end
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    rsp_ready_i = 1'b0;
    n_cmp++;
    if (busy_o !== 1'b0 || req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_no_accept got busy=%b rdy=%b v=%b want 0/1/0", busy_o, req_ready_o, rsp_valid_o);
    end
    sb_q.push_back(model(a2, b2, OP_SUB.sel, OP_SUB.mode, OP_SUB.cin));
    @(posedge clk_i);
    #1;
    acc = cyc;
    req_valid_i = 1'b0;
    scramble();
    n_cmp++;
    if (busy_o !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_second_accept got busy=%b want 1", busy_o);
    end
    get_rsp(obs, at, to);
    pop_exp(e);
    n_cmp++;
    if (to || obs !== e || at - acc != N) begin
      n_bad++;
      $display("FAIL bp_second got %h/%b/%b lat=%0d want %h/%b/%b lat=%0d", obs.res, obs.co, obs.eq, at - acc, e.res, e.co, e.eq, N);
    end
    ack();
  endtask

  task automatic test_reset_abort();
    int acc, at;
    bit to;
    bit seen;
    exp_t obs, e;
    do_req(16'h7777, 16'h1111, OP_ADD.sel, OP_ADD.mode, 1'b0, acc, to);
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b0;
    #1;
    n_cmp++;
    if (all_outs() !== 34'd0) begin
      n_bad++;
      $display("FAIL abort_outs got %h want 0", all_outs());
    end
    pop_exp(e);
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk_i);
      if (rsp_valid_o !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL abort_no_rsp got rsp_valid=1 want 0");
    end
    do_req(16'h0F0F, 16'hF0F0, OP_AND.sel, OP_AND.mode, 1'b0, acc, to);
    get_rsp(obs, at, to);
    pop_exp(e);
    n_cmp++;
    if (to || obs !== e || at - acc != N) begin
      n_bad++;
      $display("FAIL abort_next got %h/%b/%b lat=%0d want %h/%b/%b lat=%0d", obs.res, obs.co, obs.eq, at - acc, e.res, e.co, e.eq, N);
    end
    ack();
  endtask

  task automatic test_back_to_back();
    op_t ops[4];
    op_t op;
    int acc, at;
    bit to;
    exp_t obs, e;
    ops = '{OP_ADD, OP_SUB, OP_XOR, OP_AND};
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      op = ops[$urandom_range(0, 3)];
      do_req(W'($urandom), W'($urandom), op.sel, op.mode, 1'($urandom), acc, to);
      get_rsp(obs, at, to);
      pop_exp(e);
      n_cmp++;
      if (to || obs !== e || at - acc != N) begin
        n_bad++;
        $display("FAIL b2b_%0d got %h/%b/%b lat=%0d want %h/%b/%b lat=%0d", i, obs.res, obs.co, obs.eq, at - acc, e.res, e.co, e.eq, N);
      end
    end
    @(posedge clk_i);
    #1;
    rsp_ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_xor();
    test_sub();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
